// File: rtl/i2c_reg_target.sv
// i2c_reg_target: I2C target with a REGCOUNT x 8-bit register file, auto-increment pointer,
// per-register write protection and a one-cycle write-notify strobe.
module i2c_reg_target #(
  parameter int REGCOUNT = 16,
  parameter logic [6:0] DEV_ADDR = 7'h49,
  parameter logic [REGCOUNT-1:0] WP_MASK = '0,
  localparam int PW = (REGCOUNT > 2) ? $clog2(REGCOUNT) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_oe,
  output logic [8*REGCOUNT-1:0] registers_packed,
  output logic                  wr_strobe,
  output logic [PW-1:0]         wr_index,
  output logic                  busy
);
  typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT} state_t;
  state_t state_q, state_d;
  logic [2:0] scl_q, sda_q;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic [PW-1:0] ptr_q, ptr_d, idx_q, idx_d, ptr_nx;
  logic oe_q, oe_d, busy_q, busy_d, rw_q, rw_d, ph_q, ph_d, stb_q, stb_d, we;
  logic [7:0] regs_q [REGCOUNT];
  logic [7:0] rd;
  logic scl, sda, rise, fall, start, stop, hit, ptr_ok;
  // bit 1 is the synchronised pin value, bit 2 its previous sample for edge detection
  assign scl = scl_q[1];
  assign sda = sda_q[1];
  assign rise = scl & ~scl_q[2];
  assign fall = ~scl & scl_q[2];
  assign start = scl & scl_q[2] & sda_q[2] & ~sda;
  assign stop = scl & scl_q[2] & ~sda_q[2] & sda;
  assign hit = sh_q[7:1] == DEV_ADDR;
  assign ptr_ok = {1'b0, sh_q} < 9'(REGCOUNT);
  assign ptr_nx = (ptr_q == PW'(REGCOUNT - 1)) ? '0 : ptr_q + PW'(1);
  assign rd = regs_q[ptr_q];
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    ptr_d = ptr_q;
    oe_d = oe_q;
    busy_d = busy_q;
    rw_d = rw_q;
    ph_d = ph_q;
    idx_d = idx_q;
    stb_d = 1'b0;
    we = 1'b0;
    if (stop) begin
      state_d = IDLE;
      oe_d = 1'b0;
      busy_d = 1'b0;
    end else if (start) begin
      state_d = ADDR;
      cnt_d = 4'd0;
      oe_d = 1'b0;
      busy_d = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WDATA:
          if (rise && cnt_q < 4'd8) begin
            sh_d = {sh_q[6:0], sda};
            cnt_d = cnt_q + 4'd1;
          end else if (cnt_q == 4'd8) begin
            ph_d = 1'b0;
            if (state_q == ADDR) begin
              rw_d = sh_q[0];
              busy_d = hit;
              state_d = hit ? ADDR_ACK : WAIT;
            end else if (state_q == PTR) begin
              ptr_d = ptr_ok ? sh_q[PW-1:0] : ptr_q;
              busy_d = ptr_ok;
              state_d = ptr_ok ? PTR_ACK : WAIT;
            end else begin
              we = ~WP_MASK[ptr_q];
              stb_d = we;
              idx_d = we ? ptr_q : idx_q;
              ptr_d = ptr_nx;
              state_d = WDATA_ACK;
            end
          end
        // first SCL fall drives the ACK, second one ends the ACK clock
        ADDR_ACK, PTR_ACK, WDATA_ACK:
          if (fall) begin
            ph_d = ~ph_q;
            oe_d = ~ph_q;
            cnt_d = 4'd0;
            if (ph_q) begin
              state_d = (state_q != ADDR_ACK) ? WDATA : rw_q ? RDATA : PTR;
              sh_d = (state_q == ADDR_ACK && rw_q) ? rd : sh_q;
              oe_d = (state_q == ADDR_ACK && rw_q) ? ~rd[7] : 1'b0;
            end
          end
        RDATA:
          if (rise) cnt_d = cnt_q + 4'd1;
          else if (fall && cnt_q == 4'd8) begin
            oe_d = 1'b0;
            ph_d = 1'b0;
            state_d = RACK;
          end else if (fall) begin
            sh_d = {sh_q[6:0], 1'b0};
            oe_d = ~sh_q[6];
          end
        RACK:
          if (rise && !ph_q) begin
            ptr_d = sda ? ptr_q : ptr_nx;
            ph_d = ~sda;
            busy_d = ~sda;
            state_d = sda ? WAIT : RACK;
          end else if (fall && ph_q) begin
            sh_d = rd;
            oe_d = ~rd[7];
            cnt_d = 4'd0;
            ph_d = 1'b0;
            state_d = RDATA;
          end
        WAIT: begin
          oe_d = 1'b0;
          busy_d = 1'b0;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      scl_q <= '1;
      sda_q <= '1;
      cnt_q <= '0;
      sh_q <= '0;
      ptr_q <= '0;
      idx_q <= '0;
      oe_q <= 1'b0;
      busy_q <= 1'b0;
      rw_q <= 1'b0;
      ph_q <= 1'b0;
      stb_q <= 1'b0;
      for (int k = 0; k < REGCOUNT; k++) regs_q[k] <= '0;
    end else begin
      state_q <= state_d;
      scl_q <= {scl_q[1:0], scl_in};
      sda_q <= {sda_q[1:0], sda_in};
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      ptr_q <= ptr_d;
      idx_q <= idx_d;
      oe_q <= oe_d;
      busy_q <= busy_d;
      rw_q <= rw_d;
      ph_q <= ph_d;
      stb_q <= stb_d;
      if (we) regs_q[ptr_q] <= sh_q;
    end
  end
  for (genvar i = 0; i < REGCOUNT; i++) begin : g_pk
    assign registers_packed[8*i +: 8] = regs_q[i];
  end
  assign sda_oe = oe_q;
  assign busy = busy_q;
  assign wr_strobe = stb_q;
  assign wr_index = idx_q;
endmodule

// File: tb/tb_i2c_reg_target.sv
// tb_i2c_reg_target: bit-banged I2C controller driving the target, checked against a
// transaction-level model of the register file, pointer, busy flag and write strobes.
module tb_i2c_reg_target;
  localparam int H = 10;
  localparam logic [15:0] WP = 16'h0020;
  localparam logic [6:0] DEV = 7'h49;
  logic clock = 0, reset = 0, scl_m = 1, sda_m = 1;
  logic sda_oe, wr_strobe, busy, sda_line;
  logic [127:0] registers_packed;
  logic [3:0] wr_index;
  assign sda_line = sda_m & ~sda_oe;
  i2c_reg_target #(.REGCOUNT(16), .DEV_ADDR(DEV), .WP_MASK(WP)) dut (
    .clock(clock), .reset(reset), .scl_in(scl_m), .sda_in(sda_line), .sda_oe(sda_oe),
    .registers_packed(registers_packed), .wr_strobe(wr_strobe), .wr_index(wr_index), .busy(busy)
  );
  always #5 clock = ~clock;
  int n_vec = 0, n_bad = 0;
  logic [7:0] m_regs [16];
  int m_ptr = 0, m_ph = 0;
  logic m_busy = 0;
  int exp_q[$], seen_idx[$];
  int strobe_cnt = 0;
  logic oe_seen = 0, busy_seen = 0, quiet = 0, m_own = 0, chk_on = 0;
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  function automatic logic [127:0] m_pack();
    logic [127:0] p;
    for (int k = 0; k < 16; k++) p[8*k +: 8] = m_regs[k];
    return p;
  endfunction
  always begin
    @(posedge clock);
    #2;
    if (chk_on) begin
      if (quiet) begin
        check("regs", registers_packed, m_pack());
        check("busy", busy, m_busy);
        check("idle_strobe", wr_strobe, 1'b0);
      end
      if (m_own) check("oe_release", sda_oe, 1'b0);
      if (wr_strobe) begin
        strobe_cnt++;
        seen_idx.push_back(int'(wr_index));
        check("strobe_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("wr_index", wr_index, exp_q.pop_front());
      end
      if (sda_oe) oe_seen = 1;
      if (busy) busy_seen = 1;
    end
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic bit_tx(input logic b, input logic own, output logic s);
    tick(H/2);
    sda_m = b;
    tick(H/2);
    scl_m = 1;
    tick(1);
    m_own = own;
    tick(H-2);
    m_own = 0;
    s = sda_line;
    tick(1);
    scl_m = 0;
  endtask
  task automatic bus_start();
    quiet = 0;
    sda_m = 1;
    tick(H/2);
    scl_m = 1;
    tick(H);
    sda_m = 0;
    tick(H);
    scl_m = 0;
    m_ph = 1;
    m_busy = 0;
    quiet = 1;
  endtask
  task automatic bus_stop();
    quiet = 0;
    tick(H/2);
    sda_m = 0;
    tick(H/2);
    scl_m = 1;
    tick(H);
    sda_m = 1;
    tick(H);
    m_ph = 0;
    m_busy = 0;
    quiet = 1;
  endtask
  // phases: 1 address, 2 pointer, 3 write data, 4 read data, 5 ignored until START/STOP
  task automatic send_byte(input logic [7:0] b, output logic ack);
    int ph0;
    logic ea, s;
    quiet = 0;
    ph0 = m_ph;
    ea = (ph0 == 1) ? (b[7:1] != DEV) : (ph0 == 2) ? (b >= 16) : (ph0 == 3) ? 1'b0 : 1'b1;
    if (ph0 == 3 && !WP[m_ptr]) exp_q.push_back(m_ptr);
    for (int i = 7; i >= 0; i--) bit_tx(b[i], 1'b1, s);
    bit_tx(1'b1, 1'b0, ack);
    check("ack", ack, ea);
    if (ph0 == 1) begin
      m_busy = !ea;
      m_ph = ea ? 5 : b[0] ? 4 : 2;
    end else if (ph0 == 2) begin
      if (!ea) m_ptr = b;
      m_busy = !ea;
      m_ph = ea ? 5 : 3;
    end else if (ph0 == 3) begin
      if (!WP[m_ptr]) m_regs[m_ptr] = b;
      check("strobe_done", exp_q.size(), 0);
      m_ptr = (m_ptr + 1) % 16;
    end
    quiet = 1;
  endtask
  task automatic recv_byte(input logic mack, output logic [7:0] d);
    logic s;
    logic [7:0] e;
    quiet = 0;
    e = (m_ph == 4) ? m_regs[m_ptr] : 8'hFF;
    for (int i = 7; i >= 0; i--) begin
      bit_tx(1'b1, 1'b0, s);
      d[i] = s;
    end
    bit_tx(mack, 1'b1, s);
    check("rdata", d, e);
    if (m_ph == 4) begin
      if (!mack) m_ptr = (m_ptr + 1) % 16;
      else begin
        m_ph = 5;
        m_busy = 0;
      end
    end
    quiet = 1;
  endtask
  task automatic model_reset();
    for (int k = 0; k < 16; k++) m_regs[k] = 8'h00;
    m_ptr = 0;
    m_ph = 0;
    m_busy = 0;
    exp_q.delete();
  endtask
  logic a0, a1, a2, a;
  logic [7:0] d0, d1, d;
  logic [6:0] a7;
  int sc, k, n;
  logic bad;
  initial begin
    model_reset();
    tick(4);
    check("rst_oe", sda_oe, 1'b0);
    check("rst_regs", registers_packed, 128'h0);
    check("rst_strobe", wr_strobe, 1'b0);
    check("rst_index", wr_index, 4'd0);
    check("rst_busy", busy, 1'b0);
    reset = 1;
    tick(2);
    chk_on = 1;
    quiet = 1;
    sc = strobe_cnt;
    seen_idx.delete();
    bus_start();
    send_byte(8'h92, a0);
    send_byte(8'h03, a1);
    send_byte(8'hA5, a2);
    bus_stop();
    check("t1_acks", {a0, a1, a2}, 3'b000);
    check("t1_reg3", registers_packed[31:24], 8'hA5);
    check("t1_strobes", strobe_cnt - sc, 1);
    check("t1_idx", seen_idx.size() > 0 ? seen_idx[0] : -1, 3);
    check("t1_busy", busy, 1'b0);
    seen_idx.delete();
    bus_start();
    send_byte(8'h92, a);
    send_byte(8'h0E, a);
    send_byte(8'h11, a);
    send_byte(8'h22, a);
    send_byte(8'h33, a);
    bus_stop();
    check("t2_reg14", registers_packed[119:112], 8'h11);
    check("t2_reg15", registers_packed[127:120], 8'h22);
    check("t2_reg0", registers_packed[7:0], 8'h33);
    check("t2_nidx", seen_idx.size(), 3);
    if (seen_idx.size() == 3) begin
      check("t2_idx0", seen_idx[0], 14);
      check("t2_idx1", seen_idx[1], 15);
      check("t2_idx2", seen_idx[2], 0);
    end
    oe_seen = 0;
    busy_seen = 0;
    sc = strobe_cnt;
    bus_start();
    send_byte(8'h90, a0);
    send_byte(8'h03, a1);
    send_byte(8'h55, a2);
    bus_stop();
    check("t3_acks", {a0, a1, a2}, 3'b111);
    check("t3_oe", oe_seen, 1'b0);
    check("t3_busy", busy_seen, 1'b0);
    check("t3_strobes", strobe_cnt - sc, 0);
    check("t3_reg3", registers_packed[31:24], 8'hA5);
    bus_start();
    send_byte(8'h92, a);
    send_byte(8'h02, a);
    send_byte(8'hC3, a);
    send_byte(8'h5A, a);
    bus_stop();
    bus_start();
    send_byte(8'h92, a);
    send_byte(8'h02, a);
    bus_start();
    send_byte(8'h93, a);
    recv_byte(1'b0, d0);
    recv_byte(1'b1, d1);
    bus_stop();
    check("t4_byte0", d0, 8'hC3);
    check("t4_byte1", d1, 8'h5A);
    check("t4_oe_end", sda_oe, 1'b0);
    sc = strobe_cnt;
    bus_start();
    send_byte(8'h92, a0);
    send_byte(8'h05, a1);
    send_byte(8'hFF, a2);
    check("t5_acks", {a0, a1, a2}, 3'b000);
    bus_start();
    send_byte(8'h92, a0);
    send_byte(8'h10, a1);
    bus_stop();
    check("t5_ptr_nack", a1, 1'b1);
    check("t5_reg5", registers_packed[47:40], 8'h00);
    check("t5_strobes", strobe_cnt - sc, 0);
    bus_start();
    send_byte(8'h92, a);
    send_byte(8'h01, a);
    send_byte(8'h01, a);
    bus_stop();
    bus_start();
    send_byte(8'h92, a);
    send_byte(8'h01, a);
    bus_start();
    send_byte(8'h93, a);
    tick(6);
    check("t6_oe_drive", sda_oe, 1'b1);
    quiet = 0;
    reset = 0;
    tick(1);
    reset = 1;
    check("t6_oe", sda_oe, 1'b0);
    check("t6_regs", registers_packed, 128'h0);
    check("t6_busy", busy, 1'b0);
    model_reset();
    quiet = 1;
    bus_start();
    send_byte(8'h93, a);
    recv_byte(1'b1, d);
    bus_stop();
    check("t6_read0", d, 8'h00);
    for (int t = 0; t < 30; t++) begin
      k = $urandom % 3;
      n = $urandom_range(1, 4);
      bad = ($urandom % 6) == 0;
      a7 = 7'($urandom);
      if (a7 == DEV) a7 = a7 ^ 7'h01;
      if (!bad) a7 = DEV;
      bus_start();
      if (k == 0) begin
        send_byte({a7, 1'b0}, a);
        send_byte(8'($urandom % 20), a);
        repeat (n) send_byte(8'($urandom), a);
      end else begin
        if (k == 2) begin
          send_byte(8'h92, a);
          send_byte(8'($urandom % 16), a);
          bus_start();
        end
        send_byte({a7, 1'b1}, a);
        for (int i = 0; i < n; i++) recv_byte(i == n - 1, d);
      end
      bus_stop();
    end
    tick(4);
    chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/i2c_reg_target.md
Name: i2c_reg_target

Overview:
Parametrised I2C target with an internal register file. It is the successor to the fixed 16-register I2C slave. Generalised in register count and device address, it adds:
- register reads with auto-increment
- pointer wrap-around
- per-register write protection
- a write-notify strobe

It sits between the chip pins (SCL/SDA via io_in/io_out) and downstream consumers of registers_packed.

Parameters:
REGCOUNT, 16, number of 8-bit registers (2..256); PW = max(1, $clog2(REGCOUNT)) is the pointer width
DEV_ADDR, 7'h49, 7-bit I2C target address
WP_MASK, '0 (REGCOUNT bits), bit i=1 makes register i read-only from I2C

Ports:
clock  input  1  system clock; all logic on its rising edge
reset  input  1  synchronous, active-low reset
scl_in  input  1  raw SCL pin, asynchronous
sda_in  input  1  raw SDA pin, asynchronous
sda_oe  output  1  1 = pull SDA low (open-drain), 0 = release
registers_packed  output  8*REGCOUNT  register i at bits [8i+7:8i]
wr_strobe  output  1  one-cycle pulse when a register is written
wr_index  output  PW  index of the register written; valid with wr_strobe
busy  output  1  1 from address match until STOP/START/NACK return to IDLE

Behaviour:
Reset:
- Reset is synchronous and active-low: reset==0 at a clock edge clears everything.
- Cleared state: sda_oe=0, all registers=0, wr_strobe=0, wr_index=0, busy=0, pointer=0, FSM=IDLE.
- Reset mid-transaction aborts at that edge; no partial byte is committed.

Input conditioning and bus events:
- scl_in and sda_in each pass through a 2-flop synchroniser; edges are detected on the synchronised values.
- Event latency from the pin is 3 clocks. The bus must be at least 8x slower than clock.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high.
- START is legal in any state: go to ADDR, clear the bit counter, keep the pointer (repeated START).
- STOP in any state: go to IDLE, sda_oe=0.
- SDA is sampled on the SCL rising-edge detect. sda_oe changes only on the SCL falling-edge detect.

FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT.
- ADDR: shift 8 bits MSB first.
  - If [7:1]==DEV_ADDR: drive ACK (sda_oe=1) for the 9th clock, set busy.
  - Otherwise: WAIT, sda_oe stays 0.
  - R/W=0 -> PTR. R/W=1 -> RDATA.
- PTR: 8 bits.
  - Value < REGCOUNT: load pointer, ACK, -> WDATA.
  - Value >= REGCOUNT: NACK, pointer unchanged, -> WAIT.
- WDATA, on the 8th bit sampled (next cycle):
  - If WP_MASK[ptr]==0: write reg[ptr], pulse wr_strobe with wr_index=ptr.
  - If protected: no write, no strobe.
  - ACK in both cases.
  - pointer = (ptr==REGCOUNT-1) ? 0 : ptr+1.
  - Stay in WDATA for the next byte.
- RDATA:
  - On entry, latch reg[ptr] into a shift register.
  - Drive bits MSB first: sda_oe = ~bit, updated on each SCL fall. Release SDA for the 9th clock.
  - A write strobe in the same cycle as the latch does not occur (the bus is single-owner).
- RACK: sample the controller's ACK.
  - SDA=0: increment the pointer with wrap, -> RDATA.
  - SDA=1 (NACK): -> WAIT.
- WAIT: sda_oe=0; leave only on START or STOP.
- busy=0 in IDLE and WAIT.

Simultaneous events: START/STOP detection takes priority over data-bit sampling in the same cycle.

Test Plan:
1. Reset released; START, 0x92, 0x03, 0xA5, STOP -> three ACKs; reg[3]=0xA5; exactly one wr_strobe with wr_index=3; busy returns 0 after STOP.
2. START, 0x92, 0x0E, 0x11, 0x22, 0x33, STOP -> reg14=0x11, reg15=0x22, reg0=0x33 (wrap); wr_index sequence 14, 15, 0.
3. START, 0x90, 0x03, 0x55, STOP -> sda_oe never asserted; registers unchanged; no wr_strobe; busy stays 0.
4. Preload reg2=0xC3, reg3=0x5A; START, 0x92, 0x02, repeated START, 0x93, read with ACK then NACK, STOP -> bytes 0xC3 then 0x5A on SDA; sda_oe released at 9th clocks and after NACK.
5. WP_MASK=16'h0020: START, 0x92, 0x05, 0xFF -> ACK; reg5 stays 0, no wr_strobe. Then START, 0x92, 0x10 -> NACK on pointer byte.
6. Mid-read with sda_oe=1, drive reset=0 for one clock -> next edge sda_oe=0, all registers 0, busy=0; a subsequent START, 0x93 reads 0x00 from reg0.
